// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-vector engine UART frame parser:
// parser states, command codes, framing bytes and length helpers.
package mxv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_CMD     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_EOF     = 3'd4
    } state_e;

    localparam logic [7:0] CMD_SET_N    = 8'h01;
    localparam logic [7:0] CMD_START    = 8'h02;
    localparam logic [7:0] CMD_LOAD_VEC = 8'h03;
    localparam logic [7:0] CMD_LOAD_MAT = 8'h04;

    localparam logic [7:0] SOF_BYTE = 8'hFE;
    localparam logic [7:0] EOF_BYTE = 8'hEF;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd >= CMD_SET_N) && (cmd <= CMD_LOAD_MAT);
    endfunction

    // L field a well-formed frame must carry for this command at matrix size n.
    function automatic logic [7:0] expected_len(input logic [7:0] cmd, input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'd0, n};
        case (cmd)
            CMD_SET_N:    return 8'd3;
            CMD_START:    return 8'd2;
            CMD_LOAD_VEC: return n8 + 8'd2;
            CMD_LOAD_MAT: return (n8 * n8) + 8'd2;
            default:      return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/mxv_idx_counter.sv
// Wrapping index counter: counts 0..limit, wraps to 0 on an enabled step at limit.
module mxv_idx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         term
);

    assign term = (count == limit);

    // Counter register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + 1'b1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mxv_frame_parser.sv
// UART frame parser for the matrix-vector engine (FE, L, CMD, payload, EF).
// Optional saturating error counter enabled by defining MXV_PARSER_ERR_CNT_EN.
module mxv_frame_parser
    import mxv_pkg::*;
#(
    parameter int MAX_N     = 8,
    parameter int DEFAULT_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [3:0]       n_cfg,
    output logic [MAX_N-1:0] fifo_wr_en,
    output logic             vec_wr_en,
    output logic [7:0]       wr_data,
    output logic [3:0]       wr_idx,
    output logic             mat_commit,
    output logic             vec_commit,
    output logic             start,
    output logic             frame_err,
    output logic             busy
`ifdef MXV_PARSER_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam logic [MAX_N-1:0] ROW0_ONEHOT = {{(MAX_N-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [7:0]       len_r, len_s;
    logic [7:0]       cmd_r, cmd_s;
    logic [7:0]       pend_r, pend_s;
    logic [3:0]       n_cfg_s;
    logic [MAX_N-1:0] fifo_wr_s;
    logic             vec_wr_s;
    logic [7:0]       wr_data_s;
    logic [3:0]       wr_idx_s;
    logic             mat_commit_s, vec_commit_s, start_s, frame_err_s;
    logic             col_en_s, row_en_s, cnt_clr_s;
    logic [3:0]       col_cnt, row_cnt, idx_limit_s;
    logic             col_term, row_term, pend_ok_s;

    assign idx_limit_s = n_cfg - 4'd1;
    assign cnt_clr_s   = (state_r != ST_PAYLOAD);
    assign pend_ok_s   = (pend_r != 8'd0) && (pend_r <= 8'(MAX_N));

    mxv_idx_counter #(.W(4)) u_col (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .en(col_en_s),
        .limit(idx_limit_s), .count(col_cnt), .term(col_term)
    );

    mxv_idx_counter #(.W(4)) u_row (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .en(row_en_s),
        .limit(idx_limit_s), .count(row_cnt), .term(row_term)
    );

    // Next-state and next-output decode for one received byte.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        cmd_s        = cmd_r;
        pend_s       = pend_r;
        n_cfg_s      = n_cfg;
        fifo_wr_s    = '0;
        vec_wr_s     = 1'b0;
        wr_data_s    = wr_data;
        wr_idx_s     = wr_idx;
        mat_commit_s = 1'b0;
        vec_commit_s = 1'b0;
        start_s      = 1'b0;
        frame_err_s  = 1'b0;
        col_en_s     = 1'b0;
        row_en_s     = 1'b0;
        if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    len_s   = rx_data;
                    state_s = ST_CMD;
                end
                ST_CMD: begin
                    cmd_s = rx_data;
                    if (cmd_known(rx_data) && (len_r == expected_len(rx_data, n_cfg))) begin
                        state_s = (rx_data == CMD_START) ? ST_EOF : ST_PAYLOAD;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    case (cmd_r)
                        CMD_LOAD_MAT: begin
                            fifo_wr_s = ROW0_ONEHOT << row_cnt;
                            wr_data_s = rx_data;
                            wr_idx_s  = col_cnt;
                            col_en_s  = 1'b1;
                            row_en_s  = col_term;
                            state_s   = (col_term && row_term) ? ST_EOF : ST_PAYLOAD;
                        end
                        CMD_LOAD_VEC: begin
                            vec_wr_s  = 1'b1;
                            wr_data_s = rx_data;
                            wr_idx_s  = col_cnt;
                            col_en_s  = 1'b1;
                            state_s   = col_term ? ST_EOF : ST_PAYLOAD;
                        end
                        CMD_SET_N: begin
                            pend_s  = rx_data;
                            state_s = ST_EOF;
                        end
                        default: begin
                            frame_err_s = 1'b1;
                            state_s     = ST_IDLE;
                        end
                    endcase
                end
                ST_EOF: begin
                    state_s = ST_IDLE;
                    if (rx_data == EOF_BYTE) begin
                        case (cmd_r)
                            CMD_LOAD_MAT: mat_commit_s = 1'b1;
                            CMD_LOAD_VEC: vec_commit_s = 1'b1;
                            CMD_START:    start_s      = 1'b1;
                            CMD_SET_N: begin
                                if (pend_ok_s) begin
                                    n_cfg_s = pend_r[3:0];
                                end else begin
                                    frame_err_s = 1'b1;
                                end
                            end
                            default: frame_err_s = 1'b1;
                        endcase
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            len_r      <= 8'd0;
            cmd_r      <= 8'd0;
            pend_r     <= 8'd0;
            n_cfg      <= 4'(DEFAULT_N);
            fifo_wr_en <= '0;
            vec_wr_en  <= 1'b0;
            wr_data    <= 8'd0;
            wr_idx     <= 4'd0;
            mat_commit <= 1'b0;
            vec_commit <= 1'b0;
            start      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            cmd_r      <= cmd_s;
            pend_r     <= pend_s;
            n_cfg      <= n_cfg_s;
            fifo_wr_en <= fifo_wr_s;
            vec_wr_en  <= vec_wr_s;
            wr_data    <= wr_data_s;
            wr_idx     <= wr_idx_s;
            mat_commit <= mat_commit_s;
            vec_commit <= vec_commit_s;
            start      <= start_s;
            frame_err  <= frame_err_s;
            busy       <= (state_s != ST_IDLE);
        end
    end

`ifdef MXV_PARSER_ERR_CNT_EN
    // Saturating count of aborted frames, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (frame_err_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end else begin
            err_count <= err_count;
        end
    end
`else
    // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_mxv_frame_parser.sv
// Table-driven directed bench for mxv_frame_parser (MAX_N = 8, DEFAULT_N = 4).
module tb_mxv_frame_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] n_cfg;
    logic [7:0] fifo_wr_en;
    logic       vec_wr_en;
    logic [7:0] wr_data;
    logic [3:0] wr_idx;
    logic       mat_commit, vec_commit, start, frame_err, busy;
`ifdef MXV_PARSER_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxv_frame_parser #(.MAX_N(8), .DEFAULT_N(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .n_cfg(n_cfg), .fifo_wr_en(fifo_wr_en), .vec_wr_en(vec_wr_en),
        .wr_data(wr_data), .wr_idx(wr_idx), .mat_commit(mat_commit),
        .vec_commit(vec_commit), .start(start), .frame_err(frame_err),
        .busy(busy)
`ifdef MXV_PARSER_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic [7:0] fifo;
        logic       vec;
        logic [7:0] wd;
        logic [3:0] wi;
        logic [3:0] flg;   // {mat_commit, vec_commit, start, frame_err}
        logic       bsy;
        logic [3:0] n;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic [7:0] f,
                                input logic ve, input logic [7:0] wd, input logic [3:0] wi,
                                input logic [3:0] flg, input logic b, input logic [3:0] n);
        vec_t r;
        r.din = d; r.vld = v; r.fifo = f; r.vec = ve; r.wd = wd; r.wi = wi;
        r.flg = flg; r.bsy = b; r.n = n;
        return r;
    endfunction

    // Control byte: no write strobe expected.
    function automatic void ctl(input logic [7:0] d, input logic b, input logic [3:0] n, input logic [3:0] flg);
        tbl.push_back(mk(d, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, flg, b, n));
    endfunction

    function automatic void vwr(input logic [7:0] d, input logic [3:0] wi, input logic [3:0] n);
        tbl.push_back(mk(d, 1'b1, 8'h00, 1'b1, d, wi, 4'b0000, 1'b1, n));
    endfunction

    task automatic apply(input vec_t r, input string tag, input int idx);
        logic ok;
        @(negedge clk);
        rx_data  = r.din;
        rx_valid = r.vld;
        @(posedge clk);
        #1;
        checks++;
        ok = (fifo_wr_en == r.fifo) && (vec_wr_en == r.vec) && (busy == r.bsy) && (n_cfg == r.n) &&
             ({mat_commit, vec_commit, start, frame_err} == r.flg);
        if ((r.fifo != 8'h00) || r.vec)
            ok = ok && (wr_data == r.wd) && (wr_idx == r.wi);
        if (!ok) begin
            errors++;
            $display("FAIL %s[%0d] byte=%h: got fifo=%h vec=%b wd=%h wi=%0d flags=%b busy=%b n=%0d; want fifo=%h vec=%b wd=%h wi=%0d flags=%b busy=%b n=%0d",
                     tag, idx, r.din, fifo_wr_en, vec_wr_en, wr_data, wr_idx,
                     {mat_commit, vec_commit, start, frame_err}, busy, n_cfg,
                     r.fifo, r.vec, r.wd, r.wi, r.flg, r.bsy, r.n);
        end
    endtask

    task automatic reset_check(input string tag);
        logic ok;
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        @(posedge clk);
        #1;
        checks++;
        ok = (fifo_wr_en == 8'h00) && !vec_wr_en && (wr_data == 8'h00) && (wr_idx == 4'd0) &&
             !mat_commit && !vec_commit && !start && !frame_err && !busy && (n_cfg == 4'd4);
`ifdef MXV_PARSER_ERR_CNT_EN
        ok = ok && (err_count == 8'd0);
`endif
        if (!ok) begin
            errors++;
            $display("FAIL %s: got fifo=%h vec=%b wd=%h wi=%0d flags=%b busy=%b n=%0d; want all zero, n=4",
                     tag, fifo_wr_en, vec_wr_en, wr_data, wr_idx,
                     {mat_commit, vec_commit, start, frame_err}, busy, n_cfg);
        end
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        int exp_errs;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Garbage in IDLE is dropped silently.
        ctl(8'h55, 1'b0, 4'd4, 4'b0000);
        // LOAD_MAT N=4: rows steered one-hot, columns 0..3.
        ctl(8'hFE, 1'b1, 4'd4, 4'b0000);
        ctl(8'h12, 1'b1, 4'd4, 4'b0000);
        ctl(8'h04, 1'b1, 4'd4, 4'b0000);
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(8'(i), 1'b1, 8'(1 << (i / 4)), 1'b0, 8'(i), 4'(i % 4), 4'b0000, 1'b1, 4'd4));
        ctl(8'hEF, 1'b0, 4'd4, 4'b1000);
        // SET_N 3.
        ctl(8'hFE, 1'b1, 4'd4, 4'b0000);
        ctl(8'h03, 1'b1, 4'd4, 4'b0000);
        ctl(8'h01, 1'b1, 4'd4, 4'b0000);
        ctl(8'h03, 1'b1, 4'd4, 4'b0000);
        ctl(8'hEF, 1'b0, 4'd3, 4'b0000);
        // LOAD_VEC N=3 with an idle gap mid-payload.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h05, 1'b1, 4'd3, 4'b0000);
        ctl(8'h03, 1'b1, 4'd3, 4'b0000);
        vwr(8'hAA, 4'd0, 4'd3);
        tbl.push_back(mk(8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd3));
        vwr(8'hBB, 4'd1, 4'd3);
        vwr(8'hCC, 4'd2, 4'd3);
        ctl(8'hEF, 1'b0, 4'd3, 4'b0100);
        // Bad length, then trailing bytes ignored.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h10, 1'b1, 4'd3, 4'b0000);
        ctl(8'h04, 1'b0, 4'd3, 4'b0001);
        ctl(8'h00, 1'b0, 4'd3, 4'b0000);
        ctl(8'hEF, 1'b0, 4'd3, 4'b0000);
        ctl(8'h11, 1'b0, 4'd3, 4'b0000);
        // Bad end byte on LOAD_VEC.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h05, 1'b1, 4'd3, 4'b0000);
        ctl(8'h03, 1'b1, 4'd3, 4'b0000);
        vwr(8'h01, 4'd0, 4'd3);
        vwr(8'h02, 4'd1, 4'd3);
        vwr(8'h03, 4'd2, 4'd3);
        ctl(8'h00, 1'b0, 4'd3, 4'b0001);
        // SET_N out of range: 0 and MAX_N+1.
        for (int k = 0; k < 2; k++) begin
            ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
            ctl(8'h03, 1'b1, 4'd3, 4'b0000);
            ctl(8'h01, 1'b1, 4'd3, 4'b0000);
            ctl((k == 0) ? 8'h00 : 8'h09, 1'b1, 4'd3, 4'b0000);
            ctl(8'hEF, 1'b0, 4'd3, 4'b0001);
        end
        // START.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h02, 1'b1, 4'd3, 4'b0000);
        ctl(8'h02, 1'b1, 4'd3, 4'b0000);
        ctl(8'hEF, 1'b0, 4'd3, 4'b0010);
        // Payload bytes FE/EF are data.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h05, 1'b1, 4'd3, 4'b0000);
        ctl(8'h03, 1'b1, 4'd3, 4'b0000);
        vwr(8'hFE, 4'd0, 4'd3);
        vwr(8'hEF, 4'd1, 4'd3);
        vwr(8'hFE, 4'd2, 4'd3);
        ctl(8'hEF, 1'b0, 4'd3, 4'b0100);
        // Unknown command.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h02, 1'b1, 4'd3, 4'b0000);
        ctl(8'h07, 1'b0, 4'd3, 4'b0001);
        // START ending in FE: error, and that FE does not open a frame.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h02, 1'b1, 4'd3, 4'b0000);
        ctl(8'h02, 1'b1, 4'd3, 4'b0000);
        ctl(8'hFE, 1'b0, 4'd3, 4'b0001);
        ctl(8'h02, 1'b0, 4'd3, 4'b0000);
        // SET_N to MAX_N.
        ctl(8'hFE, 1'b1, 4'd3, 4'b0000);
        ctl(8'h03, 1'b1, 4'd3, 4'b0000);
        ctl(8'h01, 1'b1, 4'd3, 4'b0000);
        ctl(8'h08, 1'b1, 4'd3, 4'b0000);
        ctl(8'hEF, 1'b0, 4'd8, 4'b0000);

        exp_errs = 0;
        foreach (tbl[i]) if (tbl[i].flg[0]) exp_errs++;

        repeat (2) @(posedge clk);
        reset_check("reset_state");

        foreach (tbl[i]) apply(tbl[i], "tbl", i);

`ifdef MXV_PARSER_ERR_CNT_EN
        checks++;
        if (err_count != 8'(exp_errs)) begin
            errors++;
            $display("FAIL err_count: got %0d want %0d", err_count, exp_errs);
        end
`endif

        // Matrix at N=8 (L=0x42) abandoned by reset after 5 payload bytes.
        apply(mk(8'hFE, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd8), "mid", 0);
        apply(mk(8'h42, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd8), "mid", 1);
        apply(mk(8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd8), "mid", 2);
        for (int i = 0; i < 5; i++)
            apply(mk(8'h30 + 8'(i), 1'b1, 8'h01, 1'b0, 8'h30 + 8'(i), 4'(i), 4'b0000, 1'b1, 4'd8), "mid_pl", i);
        reset_check("reset_midframe");
        apply(mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b0, 4'd4), "post_rst", 0);

        // Fresh full matrix at N=4 completes normally.
        apply(mk(8'hFE, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd4), "fresh", 0);
        apply(mk(8'h12, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd4), "fresh", 1);
        apply(mk(8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b1, 4'd4), "fresh", 2);
        for (int i = 0; i < 16; i++)
            apply(mk(8'hC0 + 8'(i), 1'b1, 8'(1 << (i / 4)), 1'b0, 8'hC0 + 8'(i), 4'(i % 4), 4'b0000, 1'b1, 4'd4), "fresh_pl", i);
        apply(mk(8'hEF, 1'b1, 8'h00, 1'b0, 8'h00, 4'd0, 4'b1000, 1'b0, 4'd4), "fresh_eof", 0);
        apply(mk(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'b0000, 1'b0, 4'd4), "fresh_after", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
